// File: rtl/noc_monitor_pkg.sv
// Shared definitions for the NoC link monitor: the per-link FSM state
// encoding, the bit positions of the error flags and the statistics
// counter widths.
package noc_monitor_pkg;

    // Per-link packet parser state
    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_SIZE    = 2'd1,
        ST_PAYLOAD = 2'd2
    } link_state_t;

    // Bit positions inside a link's error vector
    localparam int ERR_STABLE  = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_SIZE    = 2;
    localparam int NUM_ERR     = 3;

    // Widths of the optional statistics counters
    localparam int FLIT_CNT_W  = 32;
    localparam int PKT_CNT_W   = 16;

endpackage

// File: rtl/noc_port_monitor.sv
// Monitor for a single credit-based link: parses header/size/payload,
// flags protocol violations and, when NOC_MONITOR_STATS_EN is defined,
// keeps free-running flit and packet counters.
module noc_port_monitor
    import noc_monitor_pkg::*;
#(
    parameter int FLIT_WIDTH  = 16,
    parameter int MAX_PAYLOAD = 128,
    parameter int TIMEOUT     = 256
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx,
    input  logic [FLIT_WIDTH-1:0] i_data,
    input  logic                  i_credit,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_pkt_done,
`ifdef NOC_MONITOR_STATS_EN
    output logic [FLIT_CNT_W-1:0] o_flit_count,
    output logic [PKT_CNT_W-1:0]  o_pkt_count,
`endif
    output logic [NUM_ERR-1:0]    o_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [FLIT_WIDTH-1:0] SIZE_MAX = FLIT_WIDTH'(MAX_PAYLOAD);

    logic w_xfer;
    logic w_stall;
    assign w_xfer  = i_rx & i_credit;
    assign w_stall = i_rx & ~i_credit;

    link_state_t           r_state;
    link_state_t           w_state_next;
    logic [FLIT_WIDTH-1:0] r_remain;
    logic [FLIT_WIDTH-1:0] w_remain_next;
    logic                  w_done_next;
    logic                  r_done;

    // Next-state logic: each state is left only on a transfer
    always_comb begin
        w_state_next  = r_state;
        w_remain_next = r_remain;
        w_done_next   = 1'b0;
        case (r_state)
            ST_HEADER: begin
                if (w_xfer) w_state_next = ST_SIZE;
            end
            ST_SIZE: begin
                if (w_xfer) begin
                    w_remain_next = i_data;
                    if (i_data != '0) begin
                        w_state_next = ST_PAYLOAD;
                    end else begin
                        w_state_next = ST_HEADER;
                        w_done_next  = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer) begin
                    w_remain_next = r_remain - 1'b1;
                    if (r_remain == FLIT_WIDTH'(1)) begin
                        w_state_next = ST_HEADER;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next  = ST_HEADER;
                w_remain_next = '0;
            end
        endcase
    end

    // FSM state, remaining count and the registered completion pulse
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_HEADER;
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_remain <= w_remain_next;
            r_done   <= w_done_next;
        end
    end

    logic                  r_stall_prev;
    logic [FLIT_WIDTH-1:0] r_data_prev;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_next;
    logic [NUM_ERR-1:0]    w_viol;
    logic [NUM_ERR-1:0]    r_err;

    // Wait counter: counts stalled cycles, saturates at TIMEOUT
    always_comb begin
        w_wait_next = '0;
        if (w_stall) begin
            w_wait_next = (r_wait == WAIT_MAX) ? r_wait : r_wait + 1'b1;
        end
    end

    // A stalled flit must be held unchanged until it is accepted
    always_comb begin
        w_viol              = '0;
        w_viol[ERR_STABLE]  = r_stall_prev & (~i_rx | (i_data != r_data_prev));
        w_viol[ERR_TIMEOUT] = w_stall & (r_wait >= WAIT_MAX - 1'b1);
        w_viol[ERR_SIZE]    = (r_state == ST_SIZE) & w_xfer & (i_data > SIZE_MAX);
    end

    // Stall history, wait counter and sticky flags; clear beats a new error
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stall_prev <= 1'b0;
            r_data_prev  <= '0;
            r_wait       <= '0;
            r_err        <= '0;
        end else begin
            r_stall_prev <= w_stall;
            r_data_prev  <= i_data;
            r_wait       <= w_wait_next;
            if (i_clear) r_err <= '0;
            else         r_err <= r_err | w_viol;
        end
    end

`ifdef NOC_MONITOR_STATS_EN
    logic [FLIT_CNT_W-1:0] r_flit_count;
    logic [PKT_CNT_W-1:0]  r_pkt_count;

    // Free-running statistics, wrap naturally, untouched by clear
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flit_count <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_xfer) r_flit_count <= r_flit_count + 1'b1;
            if (r_done) r_pkt_count  <= r_pkt_count + 1'b1;
        end
    end

    assign o_flit_count = r_flit_count;
    assign o_pkt_count  = r_pkt_count;
`endif

    assign o_busy     = (r_state != ST_HEADER);
    assign o_pkt_done = r_done;
    assign o_err      = r_err;

endmodule

// File: rtl/noc_link_monitor.sv
// Top level: one noc_port_monitor per monitored link. Define
// NOC_MONITOR_STATS_EN to add per-link flit_count/pkt_count outputs.
module noc_link_monitor
    import noc_monitor_pkg::*;
#(
    parameter int NPORTS      = 5,
    parameter int FLIT_WIDTH  = 16,
    parameter int MAX_PAYLOAD = 128,
    parameter int TIMEOUT     = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NPORTS-1:0]            rx,
    input  logic [NPORTS*FLIT_WIDTH-1:0] data_in,
    input  logic [NPORTS-1:0]            credit_o,
    input  logic                         clear,
    output logic [NPORTS-1:0]            busy,
    output logic [NPORTS-1:0]            pkt_done,
`ifdef NOC_MONITOR_STATS_EN
    output logic [NPORTS*FLIT_CNT_W-1:0] flit_count,
    output logic [NPORTS*PKT_CNT_W-1:0]  pkt_count,
`endif
    output logic [NPORTS-1:0]            err_stable,
    output logic [NPORTS-1:0]            err_timeout,
    output logic [NPORTS-1:0]            err_size
);

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_link
            logic [NUM_ERR-1:0] w_err;

            noc_port_monitor #(
                .FLIT_WIDTH  (FLIT_WIDTH),
                .MAX_PAYLOAD (MAX_PAYLOAD),
                .TIMEOUT     (TIMEOUT)
            ) u_port (
                .i_clock      (clock),
                .i_reset      (reset),
                .i_rx         (rx[gi]),
                .i_data       (data_in[gi*FLIT_WIDTH +: FLIT_WIDTH]),
                .i_credit     (credit_o[gi]),
                .i_clear      (clear),
                .o_busy       (busy[gi]),
                .o_pkt_done   (pkt_done[gi]),
`ifdef NOC_MONITOR_STATS_EN
                .o_flit_count (flit_count[gi*FLIT_CNT_W +: FLIT_CNT_W]),
                .o_pkt_count  (pkt_count[gi*PKT_CNT_W +: PKT_CNT_W]),
`endif
                .o_err        (w_err)
            );

            assign err_stable[gi]  = w_err[ERR_STABLE];
            assign err_timeout[gi] = w_err[ERR_TIMEOUT];
            assign err_size[gi]    = w_err[ERR_SIZE];
        end
    endgenerate

endmodule

// File: tb/tb_noc_link_monitor.sv
// Directed testbench for noc_link_monitor (TIMEOUT=4, MAX_PAYLOAD=128).
module tb_noc_link_monitor;

    localparam int NP = 5;
    localparam int FW = 16;

    logic                 clock;
    logic                 reset;
    logic [NP-1:0]        rx;
    logic [NP*FW-1:0]     data_in;
    logic [NP-1:0]        credit_o;
    logic                 clear;
    logic [NP-1:0]        busy;
    logic [NP-1:0]        pkt_done;
    logic [NP-1:0]        err_stable;
    logic [NP-1:0]        err_timeout;
    logic [NP-1:0]        err_size;
`ifdef NOC_MONITOR_STATS_EN
    logic [NP*32-1:0]     flit_count;
    logic [NP*16-1:0]     pkt_count;
`endif

    int vectors = 0;
    int errors  = 0;

    noc_link_monitor #(
        .NPORTS      (NP),
        .FLIT_WIDTH  (FW),
        .MAX_PAYLOAD (128),
        .TIMEOUT     (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data_in     (data_in),
        .credit_o    (credit_o),
        .clear       (clear),
        .busy        (busy),
        .pkt_done    (pkt_done),
`ifdef NOC_MONITOR_STATS_EN
        .flit_count  (flit_count),
        .pkt_count   (pkt_count),
`endif
        .err_stable  (err_stable),
        .err_timeout (err_timeout),
        .err_size    (err_size)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flit(input int p, input logic [FW-1:0] v);
        data_in[p*FW +: FW] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (busy !== 5'b0 || pkt_done !== 5'b0) begin
            errors++;
            $display("FAIL reset_fsm: busy=%b done=%b want 00000/00000", busy, pkt_done);
        end
        vectors++;
        if ((err_stable | err_timeout | err_size) !== 5'b0) begin
            errors++;
            $display("FAIL reset_err: st=%b to=%b sz=%b want 0", err_stable, err_timeout, err_size);
        end
        reset = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [4:0] exp_busy;
        logic [4:0] exp_done;
        exp_busy = 5'b01111;
        exp_done = 5'b10000;
        rx = 5'b00001;
        credit_o = 5'b00001;
        for (int k = 0; k < 5; k++) begin
            set_flit(0, (k == 0) ? 16'hAAAA : (k == 1) ? 16'd3 : 16'(16'h0100 + k));
            step();
            vectors++;
            if (busy[0] !== exp_busy[k] || pkt_done[0] !== exp_done[k]) begin
                errors++;
                $display("FAIL basic_flit%0d: busy=%b done=%b want %b/%b",
                         k, busy[0], pkt_done[0], exp_busy[k], exp_done[k]);
            end
        end
        rx = 5'b0;
        step();
        vectors++;
        if (pkt_done !== 5'b0 || busy !== 5'b0) begin
            errors++;
            $display("FAIL basic_after: busy=%b done=%b want 0/0", busy, pkt_done);
        end
        vectors++;
        if ((err_stable | err_timeout | err_size) !== 5'b0) begin
            errors++;
            $display("FAIL basic_err: st=%b to=%b sz=%b want 0", err_stable, err_timeout, err_size);
        end
`ifdef NOC_MONITOR_STATS_EN
        vectors++;
        if (flit_count[31:0] !== 32'd5 || pkt_count[15:0] !== 16'd1) begin
            errors++;
            $display("FAIL basic_stats: flits=%0d pkts=%0d want 5/1", flit_count[31:0], pkt_count[15:0]);
        end
`endif
        $display("test_basic done");
    endtask

    task automatic test_size_zero();
        rx = 5'b00001;
        credit_o = 5'b00001;
        set_flit(0, 16'h00C0);
        step();
        vectors++;
        if (busy[0] !== 1'b1 || pkt_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_hdr: busy=%b done=%b want 1/0", busy[0], pkt_done[0]);
        end
        set_flit(0, 16'd0);
        step();
        vectors++;
        if (busy[0] !== 1'b0 || pkt_done[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_size: busy=%b done=%b want 0/1", busy[0], pkt_done[0]);
        end
        rx = 5'b0;
        step();
        vectors++;
        if (busy[0] !== 1'b0 || pkt_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: busy=%b done=%b want 0/0", busy[0], pkt_done[0]);
        end
        $display("test_size_zero done");
    endtask

    task automatic test_stable();
        credit_o = 5'b0;
        rx = 5'b01000;
        set_flit(3, 16'h1234);
        step();
        vectors++;
        if (err_stable !== 5'b0) begin
            errors++;
            $display("FAIL stable_early: got %b want 00000", err_stable);
        end
        set_flit(3, 16'h5678);
        step();
        vectors++;
        if (err_stable !== 5'b01000) begin
            errors++;
            $display("FAIL stable_set: got %b want 01000", err_stable);
        end
        rx = 5'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        vectors++;
        if (err_stable !== 5'b0) begin
            errors++;
            $display("FAIL stable_clear: got %b want 00000", err_stable);
        end
        step();
        vectors++;
        if (err_stable !== 5'b0 || err_timeout !== 5'b0) begin
            errors++;
            $display("FAIL stable_lost: st=%b to=%b want 0/0", err_stable, err_timeout);
        end
        $display("test_stable done");
    endtask

    task automatic test_multi_link();
        credit_o = 5'b0;
        rx = 5'b00101;
        set_flit(0, 16'h0011);
        set_flit(2, 16'h0022);
        step();
        set_flit(0, 16'h0033);
        set_flit(2, 16'h0044);
        step();
        vectors++;
        if (err_stable !== 5'b00101) begin
            errors++;
            $display("FAIL multi_stable: got %b want 00101", err_stable);
        end
        rx = 5'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        vectors++;
        if (err_stable !== 5'b0) begin
            errors++;
            $display("FAIL multi_clear: got %b want 00000", err_stable);
        end
        $display("test_multi_link done");
    endtask

    task automatic test_timeout();
        set_flit(1, 16'd0);
        set_flit(4, 16'd0);
        credit_o = 5'b0;
        rx = 5'b10010;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (err_timeout !== 5'b0) begin
                errors++;
                $display("FAIL timeout_early%0d: got %b want 00000", k, err_timeout);
            end
        end
        credit_o = 5'b00010;
        step();
        vectors++;
        if (err_timeout !== 5'b10000) begin
            errors++;
            $display("FAIL timeout_set: got %b want 10000", err_timeout);
        end
        credit_o = 5'b10010;
        step();
        vectors++;
        if (pkt_done !== 5'b00010 || err_stable !== 5'b0 || err_timeout !== 5'b10000) begin
            errors++;
            $display("FAIL timeout_xfer: done=%b st=%b to=%b want 00010/00000/10000",
                     pkt_done, err_stable, err_timeout);
        end
        rx = 5'b10000;
        step();
        vectors++;
        if (pkt_done !== 5'b10000) begin
            errors++;
            $display("FAIL timeout_done4: got %b want 10000", pkt_done);
        end
        rx = 5'b0;
        step();
        do_clear();
        vectors++;
        if (err_timeout !== 5'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b want 00000", err_timeout);
        end
        $display("test_timeout done");
    endtask

    task automatic test_size_limit();
        logic exp_busy;
        logic exp_done;
        int   bad;
        bad = 0;
        rx = 5'b00100;
        credit_o = 5'b00100;
        set_flit(2, 16'hBEEF);
        step();
        set_flit(2, 16'd129);
        step();
        vectors++;
        if (err_size !== 5'b00100) begin
            errors++;
            $display("FAIL size_flag: got %b want 00100", err_size);
        end
        for (int k = 1; k <= 129; k++) begin
            set_flit(2, 16'(k));
            step();
            exp_busy = (k < 129);
            exp_done = (k == 129);
            if (bad == 0 && (busy[2] !== exp_busy || pkt_done[2] !== exp_done)) begin
                bad = k;
                $display("FAIL size_payload%0d: busy=%b done=%b want %b/%b",
                         k, busy[2], pkt_done[2], exp_busy, exp_done);
            end
        end
        vectors++;
        if (bad != 0) errors++;
        rx = 5'b0;
        step();
        vectors++;
        if (busy !== 5'b0 || pkt_done !== 5'b0 || err_size !== 5'b00100) begin
            errors++;
            $display("FAIL size_after: busy=%b done=%b sz=%b want 0/0/00100", busy, pkt_done, err_size);
        end
        do_clear();
        vectors++;
        if (err_size !== 5'b0) begin
            errors++;
            $display("FAIL size_clear: got %b want 00000", err_size);
        end
        $display("test_size_limit done");
    endtask

    task automatic test_reset_mid();
        rx = 5'b00110;
        credit_o = 5'b00110;
        set_flit(1, 16'h1111);
        set_flit(2, 16'h2222);
        step();
        set_flit(1, 16'd2);
        set_flit(2, 16'd5);
        step();
        set_flit(1, 16'h0001);
        set_flit(2, 16'h0001);
        step();
        vectors++;
        if (busy !== 5'b00110) begin
            errors++;
            $display("FAIL rstmid_busy: got %b want 00110", busy);
        end
        reset = 1'b1;
        set_flit(1, 16'h0002);
        set_flit(2, 16'h0002);
        step();
        vectors++;
        if (busy !== 5'b0 || pkt_done !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_fsm: busy=%b done=%b want 0/0", busy, pkt_done);
        end
        reset = 1'b0;
        rx = 5'b0;
        step();
        vectors++;
        if (pkt_done !== 5'b0 || (err_stable | err_timeout | err_size) !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_after: done=%b st=%b to=%b sz=%b want 0",
                     pkt_done, err_stable, err_timeout, err_size);
        end
        rx = 5'b00100;
        set_flit(2, 16'h00AB);
        step();
        set_flit(2, 16'd0);
        step();
        vectors++;
        if (pkt_done !== 5'b00100) begin
            errors++;
            $display("FAIL rstmid_header: done=%b want 00100", pkt_done);
        end
        rx = 5'b0;
        step();
        $display("test_reset_mid done");
    endtask

    initial begin
        reset    = 1'b1;
        rx       = '0;
        data_in  = '0;
        credit_o = '0;
        clear    = 1'b0;
        test_reset();
        test_basic();
        test_size_zero();
        test_stable();
        test_multi_link();
        test_timeout();
        test_size_limit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
